// File: rtl/sreg_sipo_window_if.sv
// Stream-side bundle for sreg_sipo_window.
//   in_valid/in_data/in_ready : serial word stream (valid/ready)
//   slide/flush               : mode select (latched at count==0) and partial-frame flush (level)
//   out_valid/out_ready       : parallel vector handshake
//   out_parallel              : N_IN words, oldest in the top slice, newest in the bottom slice
//   count                     : words currently held in the shift register
// master = stream producer / vector consumer, slave = the buffer itself.
interface sreg_sipo_window_if #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned N_IN  = 9
);
    localparam int unsigned CW = $clog2(N_IN + 1);

    logic                    in_valid;
    logic [WIDTH-1:0]        in_data;
    logic                    in_ready;
    logic                    slide;
    logic                    flush;
    logic                    out_valid;
    logic                    out_ready;
    logic [N_IN*WIDTH-1:0]   out_parallel;
    logic [CW-1:0]           count;

    modport master (
        output in_valid, in_data, slide, flush, out_ready,
        input  in_ready, out_valid, out_parallel, count
    );

    modport slave (
        input  in_valid, in_data, slide, flush, out_ready,
        output in_ready, out_valid, out_parallel, count
    );
endinterface

// File: rtl/sreg_sipo_window.sv
// Serial-in / parallel-out word buffer.
// Collects N_IN words from a valid/ready stream and presents them as one
// N_IN*WIDTH vector through a registered output slot with backpressure.
// Block mode emits disjoint frames; slide mode emits one window per new word
// once the register is full. flush emits a partial frame zero-padded in the
// low slices.
// Ports:
//   clk  : rising-edge clock
//   rst  : synchronous, active-high reset
//   bus  : sreg_sipo_window_if slave modport (stream in, vector out, count)
module sreg_sipo_window #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned N_IN  = 9
) (
    input  logic                 clk,
    input  logic                 rst,
    sreg_sipo_window_if.slave    bus
);
    localparam int unsigned CW   = $clog2(N_IN + 1);
    localparam logic [CW-1:0] LAST = CW'(N_IN - 1);
    localparam logic [CW-1:0] FULL = CW'(N_IN);

    typedef enum logic {
        MODE_BLOCK = 1'b0,
        MODE_SLIDE = 1'b1
    } mode_e;

    logic [N_IN*WIDTH-1:0] sr_q, sr_d;
    logic [N_IN*WIDTH-1:0] out_q, out_d;
    logic [CW-1:0]         count_q, count_d;
    logic                  out_valid_q, out_valid_d;
    mode_e                 mode_q, mode_d;

    logic                  slot_free;
    logic                  in_ready;
    logic                  accept;
    logic [N_IN*WIDTH-1:0] sr_shift;
    mode_e                 eff_mode;
    int unsigned           pad_words;

    always_comb begin
        slot_free = !out_valid_q || bus.out_ready;
        // The word that completes a vector is only taken when the slot can load it.
        in_ready  = !bus.flush && ((count_q < LAST) || slot_free);
        accept    = bus.in_valid && in_ready;
        sr_shift  = {sr_q[(N_IN-1)*WIDTH-1:0], bus.in_data};
        // While empty, the live slide input governs the word being accepted
        // this cycle; it is also what gets latched for the rest of the frame.
        eff_mode  = (count_q == '0) ? (bus.slide ? MODE_SLIDE : MODE_BLOCK) : mode_q;
        pad_words = N_IN - 32'(count_q);

        sr_d        = sr_q;
        out_d       = out_q;
        count_d     = count_q;
        out_valid_d = out_valid_q && !bus.out_ready;
        mode_d      = eff_mode;

        if (bus.flush) begin
            if (count_q == '0 || (eff_mode == MODE_SLIDE && count_q == FULL)) begin
                sr_d    = '0;
                count_d = '0;
            end else if (slot_free) begin
                // Held words move to the top slices; zeros fill the rest.
                out_d       = sr_q << (pad_words * WIDTH);
                out_valid_d = 1'b1;
                sr_d        = '0;
                count_d     = '0;
            end
        end else if (accept) begin
            sr_d = sr_shift;
            if (eff_mode == MODE_BLOCK) begin
                if (count_q == LAST) begin
                    out_d       = sr_shift;
                    out_valid_d = 1'b1;
                    count_d     = '0;
                end else begin
                    count_d = count_q + CW'(1);
                end
            end else begin
                if (count_q >= LAST) begin
                    out_d       = sr_shift;
                    out_valid_d = 1'b1;
                    count_d     = FULL;
                end else begin
                    count_d = count_q + CW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sr_q        <= '0;
            out_q       <= '0;
            count_q     <= '0;
            out_valid_q <= 1'b0;
            mode_q      <= MODE_BLOCK;
        end else begin
            sr_q        <= sr_d;
            out_q       <= out_d;
            count_q     <= count_d;
            out_valid_q <= out_valid_d;
            mode_q      <= mode_d;
        end
    end

    assign bus.in_ready     = in_ready;
    assign bus.out_valid    = out_valid_q;
    assign bus.out_parallel = out_q;
    assign bus.count        = count_q;
endmodule

// File: tb/tb_sreg_sipo_window.sv
// Randomized self-checking bench for sreg_sipo_window against a window/queue
// reference model.
module tb_sreg_sipo_window;
    localparam int unsigned W  = 16;
    localparam int unsigned N  = 9;
    localparam int unsigned CW = $clog2(N + 1);
    localparam int unsigned NCYC = 2500;

    typedef logic [W-1:0]   word_t;
    typedef logic [N*W-1:0] vec_t;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    sreg_sipo_window_if #(.WIDTH(W), .N_IN(N)) bus ();

    sreg_sipo_window #(.WIDTH(W), .N_IN(N)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    task automatic check(input string tag, input vec_t got, input vec_t exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference model: the words held, oldest first; the presented vector.
    word_t m_held[$];
    vec_t  m_out;
    logic  m_ovalid;
    logic  m_slide;     // mode of the current frame

    function automatic vec_t pack(input word_t q[$]);
        vec_t v = '0;
        for (int i = 0; i < q.size(); i++)
            v[(N-1-i)*W +: W] = q[i];
        return v;
    endfunction

    function automatic logic model_ready(input logic fl, input logic ordy);
        logic slot_free = !m_ovalid || ordy;
        return !fl && ((m_held.size() < N - 1) || slot_free);
    endfunction

    task automatic model_step(input logic r, input logic iv, input word_t d,
                              input logic sl, input logic fl, input logic ordy);
        logic mode_now, slot_free, rdy;
        if (r) begin
            m_held.delete();
            m_out    = '0;
            m_ovalid = 1'b0;
            m_slide  = 1'b0;
            return;
        end
        mode_now  = (m_held.size() == 0) ? sl : m_slide;
        slot_free = !m_ovalid || ordy;
        rdy       = model_ready(fl, ordy);
        m_ovalid  = m_ovalid && !ordy;
        m_slide   = mode_now;
        if (fl) begin
            if (m_held.size() == 0 || (mode_now && m_held.size() == N)) begin
                m_held.delete();
            end else if (slot_free) begin
                m_out    = pack(m_held);
                m_ovalid = 1'b1;
                m_held.delete();
            end
        end else if (iv && rdy) begin
            m_held.push_back(d);
            if (m_held.size() > N) void'(m_held.pop_front());
            if (m_held.size() == N) begin
                m_out    = pack(m_held);
                m_ovalid = 1'b1;
                if (!mode_now) m_held.delete();
            end
        end
    endtask

    initial begin
        int unsigned phase;
        int unsigned p_valid, p_ordy, p_flush, p_rst, p_slide_flip;
        logic exp_rdy;

        rst              = 1'b1;
        bus.in_valid     = 1'b0;
        bus.in_data      = '0;
        bus.slide        = 1'b0;
        bus.flush        = 1'b0;
        bus.out_ready    = 1'b0;
        model_step(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0);

        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", vec_t'(bus.out_valid), vec_t'(1'b0));
        check("rst_count",     vec_t'(bus.count),     '0);
        check("rst_out_par",   bus.out_parallel,      '0);

        for (int cyc = 0; cyc < NCYC; cyc++) begin
            @(negedge clk);
            phase = cyc / 500;
            case (phase)
                0: begin p_valid = 95; p_ordy = 100; p_flush = 0;  p_rst = 0; p_slide_flip = 0;  end
                1: begin p_valid = 85; p_ordy = 30;  p_flush = 3;  p_rst = 0; p_slide_flip = 0;  end
                2: begin p_valid = 85; p_ordy = 80;  p_flush = 2;  p_rst = 0; p_slide_flip = 5;  end
                3: begin p_valid = 70; p_ordy = 50;  p_flush = 12; p_rst = 1; p_slide_flip = 20; end
                default: begin p_valid = 60; p_ordy = 60; p_flush = 8; p_rst = 3; p_slide_flip = 50; end
            endcase
            rst           = ($urandom_range(0, 99) < p_rst);
            bus.in_valid  = ($urandom_range(0, 99) < p_valid);
            bus.in_data   = W'($urandom);
            bus.out_ready = ($urandom_range(0, 99) < p_ordy);
            bus.flush     = ($urandom_range(0, 99) < p_flush);
            if (phase == 0 || phase == 1)
                bus.slide = 1'b0;
            else if (phase == 2 && cyc % 500 == 0)
                bus.slide = 1'b1;
            else if ($urandom_range(0, 99) < p_slide_flip)
                bus.slide = ~bus.slide;

            #1;
            exp_rdy = model_ready(bus.flush, bus.out_ready);
            if (!rst)
                check("in_ready", vec_t'(bus.in_ready), vec_t'(exp_rdy));

            @(posedge clk);
            #1;
            model_step(rst, bus.in_valid, bus.in_data, bus.slide, bus.flush, bus.out_ready);
            check("out_valid",    vec_t'(bus.out_valid), vec_t'(m_ovalid));
            check("count",        vec_t'(bus.count),     vec_t'(m_held.size()));
            check("out_parallel", bus.out_parallel,      m_out);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
